// File: rtl/overdrive_pkg.sv
// overdrive_pkg: shared types and default constants for the overdrive engine.
// Optional build macro OVERDRIVE_SOFT_CLIP_EN (used by overdrive_clip) selects
// a soft-knee clipper in place of the hard clipper.
package overdrive_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int GAIN_W_DEF = 2;
   localparam int NUM_CH_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CLIP = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Channel counter width; a single-channel build still needs one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/overdrive_clip.sv
// overdrive_clip: combinational clipper shared by all channels.
// Default build: hard clip to +/-T.
// With OVERDRIVE_SOFT_CLIP_EN defined: soft knee above +/-T (half slope),
// followed by symmetric saturation to +/-(2^(DATA_W-1)-1).
module overdrive_clip
   import overdrive_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int GAIN_W = GAIN_W_DEF
)(
   input  logic signed [DATA_W+GAIN_W:0] prod,
   input  logic        [DATA_W-2:0]      thresh,
   output logic signed [DATA_W-1:0]      clipped
);

   localparam int PROD_W = DATA_W + GAIN_W + 1;

`ifdef OVERDRIVE_SOFT_CLIP_EN
   // One extra bit so prod-T and prod+T can never wrap.
   localparam int EXT_W = PROD_W + 1;
   localparam logic signed [EXT_W-1:0]  MAX_E = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};

   logic signed [EXT_W-1:0] prod_e;
   logic signed [EXT_W-1:0] t_pos;
   logic signed [EXT_W-1:0] t_neg;
   logic signed [EXT_W-1:0] knee;

   assign prod_e = {prod[PROD_W-1], prod};
   assign t_pos  = {{(EXT_W-DATA_W+1){1'b0}}, thresh};
   assign t_neg  = -t_pos;

   // Soft knee, then saturate symmetrically so the most negative code never appears.
   always_comb begin
      knee = prod_e;
      if (prod_e > t_pos)
         knee = t_pos + ((prod_e - t_pos) >>> 1);
      else if (prod_e < t_neg)
         knee = t_neg + ((prod_e - t_neg) >>> 1);
      clipped = knee[DATA_W-1:0];
      if (knee > MAX_E)
         clipped = MAX_D;
      else if (knee < -MAX_E)
         clipped = -MAX_D;
   end
`else
   logic signed [PROD_W-1:0] t_pos;
   logic signed [PROD_W-1:0] t_neg;
   logic signed [DATA_W-1:0] t_d;

   assign t_pos = {{(PROD_W-DATA_W+1){1'b0}}, thresh};
   assign t_neg = -t_pos;
   assign t_d   = {1'b0, thresh};

   // Hard clip to +/-T; the in-range case always fits in DATA_W.
   always_comb begin
      clipped = prod[DATA_W-1:0];
      if (prod > t_pos)
         clipped = t_d;
      else if (prod < t_neg)
         clipped = -t_d;
   end
`endif

endmodule

// File: rtl/overdrive_engine.sv
// overdrive_engine: per-frame gain-and-clip engine. One START latches a frame,
// then each channel takes a MUL cycle and a CLIP cycle; FIN pulses DONE.
// Clip style is selected at build time by OVERDRIVE_SOFT_CLIP_EN (see overdrive_clip).
module overdrive_engine
   import overdrive_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int GAIN_W = GAIN_W_DEF,
   parameter int NUM_CH = NUM_CH_DEF
)(
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     START,
   input  logic [GAIN_W-1:0]        gain,
   input  logic [DATA_W-2:0]        thresh,
   input  logic [NUM_CH*DATA_W-1:0] input_frame,
   output logic [NUM_CH*DATA_W-1:0] output_frame,
   output logic                     BUSY,
   output logic                     DONE
);

   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam int CH_W   = ch_width(NUM_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   state_t                   state_reg, state_next;
   logic [CH_W-1:0]          ch_reg;
   logic [NUM_CH*DATA_W-1:0] frame_reg;
   logic [GAIN_W-1:0]        gain_reg;
   logic [DATA_W-2:0]        thresh_reg;
   logic signed [PROD_W-1:0] prod_reg, prod_next;
   logic signed [DATA_W-1:0] sample_arr [NUM_CH];
   logic signed [DATA_W-1:0] out_arr    [NUM_CH];
   logic signed [DATA_W-1:0] sample_sel;
   logic signed [DATA_W-1:0] clip_out;
   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] gain_ext;
   logic [GAIN_W:0]          gain_p1;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign sample_arr[gi] = frame_reg[gi*DATA_W +: DATA_W];
         assign output_frame[gi*DATA_W +: DATA_W] = out_arr[gi];
      end
   endgenerate

   // Full-width signed product; multiplier gain+1 is zero-extended so it stays positive.
   assign sample_sel = sample_arr[ch_reg];
   assign sample_ext = sample_sel;
   assign gain_p1    = {1'b0, gain_reg} + {{GAIN_W{1'b0}}, 1'b1};
   assign gain_ext   = {{(PROD_W-GAIN_W-1){1'b0}}, gain_p1};
   assign prod_next  = sample_ext * gain_ext;

   overdrive_clip #(
      .DATA_W (DATA_W),
      .GAIN_W (GAIN_W)
   ) u_clip (
      .prod    (prod_reg),
      .thresh  (thresh_reg),
      .clipped (clip_out)
   );

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state and status outputs.
   always_comb begin
      state_next = state_reg;
      BUSY       = 1'b1;
      DONE       = 1'b0;
      case (state_reg)
         IDLE: begin
            BUSY = 1'b0;
            if (START)
               state_next = MUL;
         end
         MUL:  state_next = CLIP;
         CLIP: state_next = (ch_reg == LAST_CH) ? FIN : MUL;
         FIN: begin
            DONE       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame capture, channel counter, product register and output writes.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ch_reg     <= '0;
         frame_reg  <= '0;
         gain_reg   <= '0;
         thresh_reg <= '0;
         prod_reg   <= '0;
         for (int i = 0; i < NUM_CH; i++)
            out_arr[i] <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (START) begin
                  frame_reg  <= input_frame;
                  gain_reg   <= gain;
                  thresh_reg <= thresh;
                  ch_reg     <= '0;
               end
            end
            MUL: prod_reg <= prod_next;
            CLIP: begin
               out_arr[ch_reg] <= clip_out;
               if (ch_reg != LAST_CH)
                  ch_reg <= ch_reg + CH_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
